flopoco_fp2fix_4_4: RTL and testbench

- Pipelined decoder from the FloPoCo 11-bit float format (wE=4, wF=4) produced by the fadd core to signed two's-complement fixed point.
- Sits on the result side of the fadd core: datapath-facing logic and testbenches read adder results as plain fixed-point values.
- Three-stage pipeline with valid/ready flow control and overflow/NaN flags.

---
 rtl/flopoco_fp2fix_4_4_if.sv | 28 ++
 rtl/flopoco_fp2fix_4_4.sv | 141 ++++++++++++++
 tb/tb_flopoco_fp2fix_4_4.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flopoco_fp2fix_4_4_if.sv
// Handshake/data bundle for the FloPoCo (wE=4, wF=4) float to fixed-point decoder.
//   in_valid/in_ready/X       : float input stream (X = {exn[1:0], sign, exp[3:0], frac[3:0]})
//   out_valid/out_ready/Q     : signed fixed-point result stream, LSB weight 2^-WF
//   ovf/nan                   : per-result flags, qualified by out_valid
// slave  : the decoder side
// master : the producer/consumer side
interface flopoco_fp2fix_4_4_if #(
    parameter int W = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [10:0]   X;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Q;
    logic          ovf;
    logic          nan;

    modport slave (
        input  in_valid, X, out_ready,
        output in_ready, out_valid, Q, ovf, nan
    );

    modport master (
        output in_valid, X, out_ready,
        input  in_ready, out_valid, Q, ovf, nan
    );
endinterface

// File: rtl/flopoco_fp2fix_4_4.sv
// Three-stage pipelined decoder: FloPoCo float (wE=4, wF=4, bias 7) to signed
// two's-complement fixed point Q(WI).(WF), saturating, with overflow/NaN flags.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of flopoco_fp2fix_4_4_if (input stream, output stream, flags)
// Stages: 1 capture fields, 2 shift mantissa to fixed-point magnitude,
//         3 saturate/negate into the output register.
module flopoco_fp2fix_4_4 #(
    parameter int WI = 8,
    parameter int WF = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    flopoco_fp2fix_4_4_if.slave  bus
);
    localparam int W  = WI + WF;
    localparam int MW = W + 13;

    localparam logic [W-1:0]  MAX_Q = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  MIN_Q = {1'b1, {(W-1){1'b0}}};
    localparam logic [MW-1:0] LIM_P = {{(MW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [MW-1:0] LIM_N = {{(MW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    // shift = e - 11 + WF (value = mant * 2^(e-7-4))
    localparam logic signed [7:0] S_OFS = 8'(WF - 11);

    logic          w_advance;

    logic          r1_valid;
    logic [1:0]    r1_exn;
    logic          r1_sign;
    logic [3:0]    r1_e;
    logic [4:0]    r1_mant;

    logic          r2_valid;
    logic [1:0]    r2_exn;
    logic          r2_sign;
    logic [MW-1:0] r2_mag;

    logic          r3_valid;
    logic [W-1:0]  r_q;
    logic          r_ovf;
    logic          r_nan;

    logic signed [7:0] w_s;
    logic [7:0]        w_rsh;
    logic [MW-1:0]     w_mag;
    logic [W-1:0]      w_q;
    logic              w_ovf;
    logic              w_nan;

    // The whole pipe moves as one; it only stalls when the output is full and not drained.
    assign w_advance    = !r3_valid || bus.out_ready;
    assign bus.in_ready = w_advance;

    assign w_s   = $signed({4'b0000, r1_e}) + S_OFS;
    assign w_rsh = 8'(~w_s) + 8'd1;

    // Right shifts drop bits (truncate toward zero on the magnitude, before negation).
    always_comb begin
        w_mag = '0;
        if (!w_s[7]) begin
            w_mag = MW'(r1_mant) << w_s[6:0];
        end else begin
            w_mag = MW'(r1_mant >> w_rsh);
        end
    end

    always_comb begin
        w_q   = '0;
        w_ovf = 1'b0;
        w_nan = 1'b0;
        case (r2_exn)
            2'b00: ;
            2'b11: w_nan = 1'b1;
            2'b10: begin
                w_ovf = 1'b1;
                w_q   = r2_sign ? MIN_Q : MAX_Q;
            end
            default: begin
                if (!r2_sign) begin
                    if (r2_mag > LIM_P) begin
                        w_q   = MAX_Q;
                        w_ovf = 1'b1;
                    end else begin
                        w_q = r2_mag[W-1:0];
                    end
                end else begin
                    // Magnitude of exactly 2^(W-1) negates to MIN_Q without overflow.
                    if (r2_mag > LIM_N) begin
                        w_q   = MIN_Q;
                        w_ovf = 1'b1;
                    end else begin
                        w_q = -r2_mag[W-1:0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_exn   <= '0;
            r1_sign  <= 1'b0;
            r1_e     <= '0;
            r1_mant  <= '0;
            r2_valid <= 1'b0;
            r2_exn   <= '0;
            r2_sign  <= 1'b0;
            r2_mag   <= '0;
            r3_valid <= 1'b0;
            r_q      <= '0;
            r_ovf    <= 1'b0;
            r_nan    <= 1'b0;
        end else if (w_advance) begin
            r1_valid <= bus.in_valid;
            r1_exn   <= bus.X[10:9];
            r1_sign  <= bus.X[8];
            r1_e     <= bus.X[7:4];
            r1_mant  <= {1'b1, bus.X[3:0]};

            r2_valid <= r1_valid;
            r2_exn   <= r1_exn;
            r2_sign  <= r1_sign;
            r2_mag   <= w_mag;

            r3_valid <= r2_valid;
            if (r2_valid) begin
                r_q   <= w_q;
                r_ovf <= w_ovf;
                r_nan <= w_nan;
            end
        end
    end

    assign bus.out_valid = r3_valid;
    assign bus.Q         = r_q;
    assign bus.ovf       = r_ovf;
    assign bus.nan       = r_nan;

endmodule

// File: tb/tb_flopoco_fp2fix_4_4.sv
// Scoreboard bench for flopoco_fp2fix_4_4 (default Q8.8).
module tb_flopoco_fp2fix_4_4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flopoco_fp2fix_4_4_if #(.W(W)) bus ();

    flopoco_fp2fix_4_4 #(.WI(8), .WF(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [17:0] exp;
        int          cyc;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          cyc = 0;
    int          n_out = 0;
    bit          lat_chk = 1'b0;
    bit          rnd_done = 1'b0;
    logic [17:0] cur_exp = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: value = 1.f * 2^(e-7); fixed = trunc(|value| * 2^8), then sign/saturate.
    function automatic logic [17:0] model(input logic [10:0] x);
        logic [1:0]  exn;
        logic        sg;
        longint      mant;
        longint      mag;
        int          s;
        logic [15:0] q;
        exn  = x[10:9];
        sg   = x[8];
        mant = 64'd16 + longint'(x[3:0]);
        s    = int'(x[7:4]) - 11 + 8;
        if (s >= 0) mag = mant * (64'd1 << s);
        else        mag = mant / (64'd1 << (-s));
        case (exn)
            2'b00: return 18'h0;
            2'b11: return {16'h0000, 1'b0, 1'b1};
            2'b10: return sg ? {16'h8000, 2'b10} : {16'h7FFF, 2'b10};
            default: begin
                if (!sg) begin
                    if (mag > 32767) return {16'h7FFF, 2'b10};
                    q = 16'(mag);
                    return {q, 2'b00};
                end else begin
                    if (mag > 32768) return {16'h8000, 2'b10};
                    q = 16'(-mag);
                    return {q, 2'b00};
                end
            end
        endcase
    endfunction

    // Monitor: handshakes observed at the falling edge are the transfers of the next rising edge.
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (bus.in_valid && bus.in_ready) sb.push_back('{exp: cur_exp, cyc: cyc});
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", {14'd0, bus.Q, bus.ovf, bus.nan}, {14'd0, e.exp});
                        if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'd3);
                        n_out++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [10:0] x, input logic [17:0] e);
        int n;
        bus.X        = x;
        cur_exp      = e;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int base;
        logic [10:0] rx;

        bus.in_valid  = 1'b0;
        bus.X         = '0;
        bus.out_ready = 1'b1;
        #23 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_q", {16'd0, bus.Q}, 32'd0);
        chk("rst_flags", {30'd0, bus.ovf, bus.nan}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back, full throughput, fixed latency
        lat_chk = 1'b1;
        send(11'b01010000100, {16'h0280, 2'b00});
        send(11'b01010010110, {16'h0580, 2'b00});
        send(11'b01010100000, {16'h0800, 2'b00});
        send(11'b01110000100, {16'hFD80, 2'b00});
        send(11'b01011110000, {16'h7FFF, 2'b10});
        send(11'b01111110000, {16'h8000, 2'b10});
        send(11'b01011100000, {16'h7FFF, 2'b10});
        send(11'b01111100000, {16'h8000, 2'b00});
        send(11'b01000001111, {16'h0003, 2'b00});
        send(11'b01100001111, {16'hFFFD, 2'b00});
        send(11'b01000000000, {16'h0002, 2'b00});
        send(11'b00100000000, {16'h0000, 2'b00});
        send(11'b10000000000, {16'h7FFF, 2'b10});
        send(11'b10100000000, {16'h8000, 2'b10});
        send(11'b11000000000, {16'h0000, 2'b01});
        send(11'b01011010000, {16'h4000, 2'b00});
        drain();
        lat_chk = 1'b0;

        // Backpressure: stall the output for 4 cycles while 5 values are streamed
        base = n_out;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    rx = {2'b01, 1'(i & 1), 4'(7 + i), 4'(3 * i)};
                    send(rx, model(rx));
                end
            end
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!bus.out_valid && n < 50);
                chk("bp_first_valid", {31'd0, bus.out_valid}, 32'd1);
                bus.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
                    chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
                    if (sb.size() != 0)
                        chk("bp_hold", {14'd0, bus.Q, bus.ovf, bus.nan}, {14'd0, sb[0].exp});
                    else
                        chk("bp_sb_nonempty", 32'd0, 32'd1);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(n_out - base), 32'd5);

        // Random values under random output backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    rx = 11'($urandom);
                    send(rx, model(rx));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with results in flight
        send(11'b01010000100, {16'h0280, 2'b00});
        send(11'b01010010110, {16'h0580, 2'b00});
        send(11'b01010100000, {16'h0800, 2'b00});
        base = n_out;
        #1 rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_q", {16'd0, bus.Q}, 32'd0);
        chk("async_flags", {30'd0, bus.ovf, bus.nan}, 32'd0);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_stale_out", 32'(n_out - base), 32'd0);
        chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
